// File: rtl/r16_wd_align_fifo.sv
// Elastic twiddle-set buffer for the radix-16 butterfly.
// Sets are pushed by the DTFAG and popped one per butterfly data strobe.
module r16_wd_align_fifo #(
    parameter int D_WIDTH = 64,
    parameter int LANES   = 16,
    parameter int DEPTH   = 32,
    localparam int AW     = $clog2(DEPTH),
    localparam int SW     = LANES * D_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          wd_in_valid,
    output logic          wd_in_ready,
    input  logic [SW-1:0] wd_in_data,
    input  logic          data_valid,
    output logic          wd_out_valid,
    output logic [SW-1:0] wd_out_data,
    output logic [AW:0]   count,
    output logic          underflow_err
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [SW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] out_data_q, out_data_d;
    logic          err_q, err_d;
    logic          push, pop, empty;

    assign empty       = (count_q == '0);
    assign wd_in_ready = (count_q != FULL);
    // Flush wins over both sides of the handshake.
    assign push = wd_in_valid && wd_in_ready && !flush;
    assign pop  = data_valid && !empty && !flush;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = pop;
        out_data_d  = out_data_q;
        err_d       = err_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            err_d    = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d   = rd_ptr_q + 1'b1;
                out_data_d = mem_q[rd_ptr_q];
            end
            if (data_valid && empty) begin
                err_d = 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wd_in_data;
        end
    end

    assign wd_out_valid  = out_valid_q;
    assign wd_out_data   = out_data_q;
    assign count         = count_q;
    assign underflow_err = err_q;

endmodule

// File: doc/r16_wd_align_fifo.md
Name: r16_wd_align_fifo

Overview:
Receiving end of the radix-16 twiddle-factor (WD) path. It accepts 16-lane twiddle sets from the DTFAG through a valid/ready handshake and buffers them. It releases one set to the radix-16 butterfly each time the butterfly's data-side strobe arrives, which replaces the fixed-latency delay line with elastic alignment. Sets leave in strict FIFO order.

Parameters:
D_WIDTH, 64, width of one twiddle word.
LANES, 16, twiddle words per set (radix).
DEPTH, 32, number of buffered sets; must be a power of 2. Derived localparam AW = log2(DEPTH).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
flush  input  1  synchronous clear of buffer, pointers and error.
wd_in_valid  input  1  producer has a set on wd_in_data.
wd_in_ready  output  1  buffer can accept a set this cycle.
wd_in_data  input  LANES*D_WIDTH  set; lane i occupies bits [i*D_WIDTH +: D_WIDTH].
data_valid  input  1  butterfly data arrival strobe; requests one set.
wd_out_valid  output  1  wd_out_data holds a freshly popped set (one-cycle pulse per pop).
wd_out_data  output  LANES*D_WIDTH  popped set, same lane packing.
count  output  AW+1  number of sets stored, 0..DEPTH.
underflow_err  output  1  sticky: data_valid arrived while the buffer was empty.

Behaviour:
- Reset (rst_n=0, takes effect immediately): wr_ptr, rd_ptr, count = 0; wd_out_valid = 0; wd_out_data = 0; underflow_err = 0. Storage contents are don't-care.
- wd_in_ready = (count != DEPTH). It is a combinational decode of the count register with no dependency on wd_in_valid or data_valid.
- Push: when wd_in_valid && wd_in_ready, store the set at wr_ptr and advance wr_ptr modulo DEPTH.
- Pop: when data_valid && count != 0, read the set at rd_ptr and advance rd_ptr modulo DEPTH.
  - Next cycle: wd_out_valid = 1 and wd_out_data = that set.
  - Pop-to-output latency is exactly 1 cycle.
- No pop in a cycle: wd_out_valid = 0 next cycle; wd_out_data holds its last value.
- Underflow: data_valid && count == 0.
  - No pop occurs and wd_out_valid = 0 next cycle.
  - underflow_err goes to 1 next cycle and stays set until flush or reset.
  - No bypass: a push in the same cycle does not satisfy the request; the pushed set is stored.
- Simultaneous push and pop (count between 1 and DEPTH-1): both happen and count is unchanged.
- Full: at count == DEPTH a pop is still allowed and a push is refused (ready low); count becomes DEPTH-1 and ready rises the following cycle.
- Count update:
  - push only: count+1;
  - pop only: count-1;
  - both or neither: count unchanged.
- Pointers are AW bits and wrap silently; full and empty are decided from count only.
- Flush (synchronous): takes priority over push and pop in the same cycle.
  - Next cycle: pointers = 0, count = 0, underflow_err = 0, wd_out_valid = 0; wd_out_data holds its value.
- Reset mid-operation discards all buffered sets; after release the block behaves as freshly reset.
- Storage: a DEPTH x (LANES*D_WIDTH) register array with one write and one read per cycle. No reset on the array.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> wd_out_valid=0, wd_out_data=0, count=0, wd_in_ready=1, underflow_err=0.
- In-order delivery: push 3 sets where lane i of set k = 16*k+i; then pulse data_valid 3 times -> wd_out_valid asserts exactly 1 cycle after each pulse; lane 5 reads 5, 21, 37 in turn; count steps 3,2,1,0.
- Full boundary: push 32 sets -> count=32, wd_in_ready=0; a 33rd wd_in_valid is not stored. Pop plus push attempt in the same cycle -> count=31, ready=1 next cycle; the 33rd set is accepted after that and emerges last.
- Underflow: data_valid at count=0 with wd_in_valid=1 -> wd_out_valid=0, underflow_err=1 (sticky over 10 cycles), count=1. Flush -> count=0, err=0.
- Wrap-around: keep count=5 with continuous simultaneous push and pop for 80 cycles -> count stays 5 and the output sequence equals the input sequence delayed by 5 pops across pointer wraps.
- Async reset mid-stream at count=7 -> outputs clear in the same cycle without a clock edge; after release the first push/pop pair returns the new set, not stale data.
